// File: rtl/sigmoid_seg_sel.sv
// sigmoid_seg_sel: classify signed Q8.8 x into 8 PWL sigmoid segments, emit
// registered x/gradient/offset/seg_idx with valid/ready flow control.
// Ports: clk, rst (async high), in_valid/in_ready/x_in upstream,
//   out_valid/out_ready/x_out/gradient/offset/seg_idx downstream.
// Macro SIGMOID_COEF_WR_EN adds coef_we/coef_addr/coef_grad/coef_off
//   to make the coefficient table writable.
module sigmoid_seg_sel #(
  parameter int BITS      = 16,
  parameter int SEG_IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BITS-1:0]      x_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITS-1:0]      x_out,
  output logic [BITS-1:0]      gradient,
  output logic [BITS-1:0]      offset,
  output logic [SEG_IDX_W-1:0] seg_idx
`ifdef SIGMOID_COEF_WR_EN
  ,
  input  logic                 coef_we,
  input  logic [SEG_IDX_W-1:0] coef_addr,
  input  logic [BITS-1:0]      coef_grad,
  input  logic [BITS-1:0]      coef_off
`endif
);

  localparam logic [BITS-1:0] DEF_G [8] = '{
    16'h0000, 16'h0008, 16'h0020, 16'h0040,
    16'h0040, 16'h0020, 16'h0008, 16'h0000
  };
  localparam logic [BITS-1:0] DEF_O [8] = '{
    16'h0000, 16'h0028, 16'h0060, 16'h0080,
    16'h0080, 16'h00A0, 16'h00D8, 16'h0100
  };

  logic                        advance;
  logic signed [BITS-1:0]      xs;
  logic [SEG_IDX_W-1:0]        seg_c;
  logic                        s1_valid;
  logic [BITS-1:0]             s1_x;
  logic [SEG_IDX_W-1:0]        s1_seg;
  logic [BITS-1:0]             g_lu;
  logic [BITS-1:0]             o_lu;

  // Whole pipe moves together; a held output freezes both stages.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Plain signed compares: no abs(), so 0x8000 needs no special case.
  assign xs = $signed(x_in);

  always_comb begin
    seg_c = 3'd0;
    if (xs >= 16'sh0500)
      seg_c = 3'd7;
    else if (xs >= 16'sh0260)
      seg_c = 3'd6;
    else if (xs >= 16'sh0100)
      seg_c = 3'd5;
    else if (xs >= 16'sh0000)
      seg_c = 3'd4;
    else if (xs >= 16'shFF00)
      seg_c = 3'd3;
    else if (xs >= 16'shFDA0)
      seg_c = 3'd2;
    else if (xs >= 16'shFB00)
      seg_c = 3'd1;
    else
      seg_c = 3'd0;
  end

`ifdef SIGMOID_COEF_WR_EN
  logic [BITS-1:0] tbl_g [8];
  logic [BITS-1:0] tbl_o [8];

  // Writes land on the edge; a same-edge stage-2 load sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_g <= DEF_G;
      tbl_o <= DEF_O;
    end else if (coef_we) begin
      tbl_g[coef_addr] <= coef_grad;
      tbl_o[coef_addr] <= coef_off;
    end
  end

  assign g_lu = tbl_g[s1_seg];
  assign o_lu = tbl_o[s1_seg];
`else
  assign g_lu = DEF_G[s1_seg];
  assign o_lu = DEF_O[s1_seg];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_seg    <= '0;
      out_valid <= 1'b0;
      x_out     <= '0;
      seg_idx   <= '0;
      gradient  <= '0;
      offset    <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_x      <= x_in;
      s1_seg    <= seg_c;
      out_valid <= s1_valid;
      x_out     <= s1_x;
      seg_idx   <= s1_seg;
      gradient  <= g_lu;
      offset    <= o_lu;
    end
  end

endmodule

// File: tb/tb_sigmoid_seg_sel.sv
// tb_sigmoid_seg_sel: directed tables, hand sequences and randomized
// traffic against a queue-based reference model.
module tb_sigmoid_seg_sel;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x_out;
  logic [15:0] gradient;
  logic [15:0] offset;
  logic [2:0]  seg_idx;
`ifdef SIGMOID_COEF_WR_EN
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_grad;
  logic [15:0] coef_off;
`endif

  sigmoid_seg_sel dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .gradient(gradient), .offset(offset),
    .seg_idx(seg_idx)
`ifdef SIGMOID_COEF_WR_EN
    , .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_grad(coef_grad), .coef_off(coef_off)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  int bnd [7] = '{-1280, -608, -256, 0, 256, 608, 1280};
  logic [15:0] mg [8];
  logic [15:0] mo [8];
  logic [50:0] sbq [$];

  typedef struct {
    logic [15:0] x;
    logic [2:0]  seg;
  } vec_t;

  function automatic void init_model();
    mg = '{16'h0000, 16'h0008, 16'h0020, 16'h0040,
           16'h0040, 16'h0020, 16'h0008, 16'h0000};
    mo = '{16'h0000, 16'h0028, 16'h0060, 16'h0080,
           16'h0080, 16'h00A0, 16'h00D8, 16'h0100};
  endfunction

  // Segment = number of boundaries that x is at or above.
  function automatic logic [50:0] model(logic [15:0] x);
    int s = 0;
    for (int i = 0; i < 7; i++)
      if ($signed(x) >= bnd[i]) s++;
    return {x, 3'(s), mg[s], mo[s]};
  endfunction

  function automatic logic [50:0] dut_word();
    return {x_out, seg_idx, gradient, offset};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(bit v, logic [15:0] x, bit r);
    in_valid  = v;
    x_in      = x;
    out_ready = r;
  endtask

  // Observe the handshakes that the coming rising edge will perform.
  task automatic sample();
    logic [50:0] e;
    bit ok;
    #2;
    if (out_valid && out_ready) begin
      ok = sbq.size() > 0;
      e = '0;
      if (ok) e = sbq.pop_front();
      chk("sb_nonempty", 64'(ok), 64'd1);
      if (ok) chk("sb_data", 64'(dut_word()), 64'(e));
    end
    if (in_valid && in_ready) sbq.push_back(model(x_in));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
  endtask

  vec_t        vec [7];
  logic [15:0] vals [3];
  logic [2:0]  eseg [3];
  bit          pat [5];
  logic [50:0] held;
  int          idx;
  int          nd;

  initial begin
    vec[0] = '{16'hFB00, 3'd1};
    vec[1] = '{16'hFAFF, 3'd0};
    vec[2] = '{16'h0100, 3'd5};
    vec[3] = '{16'h00FF, 3'd4};
    vec[4] = '{16'h0500, 3'd7};
    vec[5] = '{16'h8000, 3'd0};
    vec[6] = '{16'h7FFF, 3'd7};
    vals = '{16'h0000, 16'h0300, 16'hFE00};
    eseg = '{3'd4, 3'd6, 3'd2};
    pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    init_model();

    rst = 1'b1;
    drive(0, 16'h0000, 1);
`ifdef SIGMOID_COEF_WR_EN
    coef_we = 1'b0; coef_addr = '0; coef_grad = '0; coef_off = '0;
`endif
    #6;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_word", 64'(dut_word()), 64'd0);
    chk("rst_inrdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single sample latency
    for (int t = 0; t < 4; t++) begin
      drive(t == 0, 16'h0080, 1);
      sample();
      chk("single_valid", 64'(out_valid), 64'(t == 2));
      if (t == 2)
        chk("single_word", 64'(dut_word()),
            64'({16'h0080, 3'd4, 16'h0040, 16'h0080}));
      @(negedge clk);
    end

    // Boundaries back-to-back
    for (int j = 0; j < 9; j++) begin
      drive(j < 7, (j < 7) ? vec[j].x : 16'h0000, 1);
      sample();
      if (j >= 2) begin
        chk("bnd_valid", 64'(out_valid), 64'd1);
        chk("bnd_seg", 64'(seg_idx), 64'(vec[j-2].seg));
        chk("bnd_x", 64'(x_out), 64'(vec[j-2].x));
      end
      @(negedge clk);
    end

    // Backpressure: 5-cycle stall after first output
    idx = 0;
    nd = 0;
    held = '0;
    for (int t = 0; t < 12; t++) begin
      drive(idx < 3, vals[(idx < 3) ? idx : 0], !(t >= 2 && t < 7));
      sample();
      if (t == 2) begin
        held = dut_word();
        chk("bp_first", 64'(held), 64'(model(16'h0000)));
      end
      if (t >= 2 && t < 7) begin
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_inrdy", 64'(in_ready), 64'd0);
      end
      if (t > 2 && t < 7)
        chk("bp_hold", 64'(dut_word()), 64'(held));
      if (out_valid && out_ready) begin
        if (nd < 3) chk("bp_seg", 64'(seg_idx), 64'(eseg[nd]));
        nd++;
      end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    chk("bp_count", 64'(nd), 64'd3);

    // Asynchronous reset with two samples in flight
    drive(1, 16'h1234, 1);
    sample();
    @(negedge clk);
    drive(1, 16'hF800, 1);
    sample();
    @(negedge clk);
    drive(0, 16'h0000, 1);
    #2;
    chk("mr_pre", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_word", 64'(dut_word()), 64'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      drive(t == 0, 16'hF000, 1);
      sample();
      chk("mr_after", 64'(out_valid), 64'(t == 2));
      if (t == 2) chk("mr_seg", 64'(seg_idx), 64'd0);
      @(negedge clk);
    end

    // Bubbles
    for (int t = 0; t < 5; t++) begin
      drive(pat[t], 16'($urandom), 1);
      sample();
      chk("bubble", 64'(out_valid), 64'((t >= 2) ? pat[t-2] : 1'b0));
      @(negedge clk);
    end

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      logic [15:0] x;
      if ($urandom_range(0, 1) == 0)
        x = 16'(bnd[$urandom_range(0, 6)] + $urandom_range(0, 2) - 1);
      else
        x = 16'($urandom);
      drive($urandom_range(0, 3) != 0, x, $urandom_range(0, 3) != 0);
      sample();
      @(negedge clk);
    end
    for (int t = 0; t < 4; t++) begin
      drive(0, 16'h0000, 1);
      sample();
      @(negedge clk);
    end
    chk("drain", 64'(sbq.size()), 64'd0);

`ifdef SIGMOID_COEF_WR_EN
    coef_we = 1'b1; coef_addr = 3'd7;
    coef_grad = 16'h0001; coef_off = 16'h00FF;
    drive(0, 16'h0000, 1);
    sample();
    @(negedge clk);
    coef_we = 1'b0;
    mg[7] = 16'h0001;
    mo[7] = 16'h00FF;
    for (int t = 0; t < 3; t++) begin
      drive(t == 0, 16'h0600, 1);
      sample();
      if (t == 2) begin
        chk("wr_grad", 64'(gradient), 64'h0001);
        chk("wr_off", 64'(offset), 64'h00FF);
      end
      @(negedge clk);
    end
    do_reset();
    init_model();
    for (int t = 0; t < 3; t++) begin
      drive(t == 0, 16'h0600, 1);
      sample();
      if (t == 2) begin
        chk("wr_rst_grad", 64'(gradient), 64'h0000);
        chk("wr_rst_off", 64'(offset), 64'h0100);
      end
      @(negedge clk);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sigmoid_seg_sel.md
Name: sigmoid_seg_sel

Overview:
- Upstream stage of the piecewise-linear sigmoid datapath.
- Classifies each signed Q8.8 input x into one of 8 PLAN-style segments.
- Emits x together with that segment's gradient/offset pair, all registered, ready for the downstream multiply-add stage (alfa = gradient*x + offset).
- 2-stage pipeline with valid/ready handshake and full backpressure support.

Parameters:
- BITS, 16, data word width; signed two's-complement Q8.8. Only 16 is supported; the segment table below is defined for Q8.8.
- SEG_IDX_W, 3, width of the segment index output; fixed to 3 (8 segments).

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  x_in is valid this cycle.
- in_ready  output  1  stage can accept x_in this cycle.
- x_in  input  BITS  signed Q8.8 sample.
- out_valid  output  1  x_out/gradient/offset/seg_idx are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- x_out  output  BITS  x_in delayed, aligned to the coefficients.
- gradient  output  BITS  Q8.8 slope for the segment.
- offset  output  BITS  Q8.8 intercept for the segment.
- seg_idx  output  3  selected segment, 0..7.

Behaviour:
- Reset: asynchronous on rst high, regardless of clock. Clears both stage valid bits and drives x_out, gradient, offset and seg_idx to 0. Data in flight is discarded, not flushed. in_ready is 1 while and after reset deasserts.
- Handshake: a transfer occurs when valid and ready are both 1. advance = !out_valid || out_ready. in_ready = advance, combinational from out_ready and internal state. No combinational path from in_valid to out_valid.
- Stage 1 (compare): on advance, capture x_in, compute seg index from signed compares and set s1_valid = in_valid.
- Stage 2 (lookup): on advance, register x, seg, table[seg] and set out_valid = s1_valid. Latency is exactly 2 cycles from accepted input to out_valid with no stall. Throughput is 1 sample per cycle.
- Stall: while out_valid && !out_ready, all registers hold. Output values must stay stable until accepted. Bubbles (invalid slots) propagate and are squeezed only by advance; no skid buffer.
- Segment map (signed compare on x, boundary value belongs to the upper segment), listed as index: range, gradient, offset:
  - 0: x < 0xFB00 (-5), gradient 0x0000, offset 0x0000
  - 1: 0xFB00 <= x < 0xFDA0 (-2.375), gradient 0x0008, offset 0x0028
  - 2: 0xFDA0 <= x < 0xFF00 (-1), gradient 0x0020, offset 0x0060
  - 3: 0xFF00 <= x < 0x0000, gradient 0x0040, offset 0x0080
  - 4: 0x0000 <= x < 0x0100, gradient 0x0040, offset 0x0080
  - 5: 0x0100 <= x < 0x0260, gradient 0x0020, offset 0x00A0
  - 6: 0x0260 <= x < 0x0500, gradient 0x0008, offset 0x00D8
  - 7: x >= 0x0500, gradient 0x0000, offset 0x0100
- Extremes: 0x8000 maps to segment 0 and 0x7FFF to segment 7. No absolute-value operation is used, so there is no overflow at -32768.

Optional Feature:
- Macro: SIGMOID_COEF_WR_EN.
- Defined: adds input ports coef_we (1 bit), coef_addr (3 bits), coef_grad (BITS) and coef_off (BITS). Table entries become registers, reset to the default map above.
- A write when coef_we=1 updates table[coef_addr] on that clock edge. Stage 2 lookups on later edges see the new value. A write on the same edge as a stage-2 load of that entry loads the old value.
- Writes are accepted during stalls; a stalled output holds its already-registered coefficients.
- Undefined: the table is constant, no extra ports are present, and behaviour is identical to reset defaults.

Test Plan:
- Single sample: x_in=0x0080, out_ready=1 -> 2 cycles later out_valid=1, seg_idx=4, gradient=0x0040, offset=0x0080, x_out=0x0080.
- Boundaries, one input per cycle: 0xFB00, 0xFAFF, 0x0100, 0x00FF, 0x0500, 0x8000, 0x7FFF -> seg_idx 1, 0, 5, 4, 7, 0, 7 in order, back-to-back outputs.
- Backpressure: stream 0x0000, 0x0300, 0xFE00 and hold out_ready=0 for 5 cycles after the first out_valid -> outputs held stable, in_ready=0 during the stall, all 3 delivered in order (seg 4, 6, 2) with no loss or duplication.
- Reset mid-operation: assert rst asynchronously with 2 samples in flight -> out_valid=0 and outputs 0 immediately; after release, next sample 0xF000 yields seg 0 only.
- Bubbles: in_valid pattern 1,0,1 with out_ready=1 -> out_valid pattern 1,0,1 starting 2 cycles later.
- SIGMOID_COEF_WR_EN: write addr 7 with grad=0x0001, off=0x00FF, then send x_in=0x0600 -> gradient=0x0001, offset=0x00FF. After reset, entry 7 returns to 0x0000/0x0100.
